adder_share_arbiter: RTL and testbench

- Shares one registered (C_DATA_WIDTH+1)-bit adder between C_REQ_NUM requesters.
- Requesters present operand pairs on a valid/ready handshake. The block grants one requester at a time in round-robin order, computes a+b, and returns the sum on a per-requester response handshake.
- Sits between the requesting datapath blocks and the arithmetic resource. It is the only path to the shared adder.

---
 rtl/adder_share_pkg.sv | 20 ++
 rtl/adder_share_arbiter_rr_pick.sv | 31 +++
 rtl/adder_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_adder_share_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM encoding and
// default sizing for operand width, requester count and grant index width.
package adder_share_pkg;

    localparam int C_DATA_WIDTH_DEF = 4;
    localparam int C_REQ_NUM_DEF    = 4;
    localparam int C_ID_WIDTH_DEF   = 2;

    // state | meaning
    // ------+------------------------------------------------------------
    // IDLE  | waiting for any requester; grant and operand capture happen here
    // CALC  | registered add of the captured operands
    // RESP  | result presented to the owner until it acknowledges
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// when scanning upward from ptr, wrapping at C_REQ_NUM.
module rr_pick
    import adder_share_pkg::*;
#(
    parameter int C_REQ_NUM  = C_REQ_NUM_DEF,
    parameter int C_ID_WIDTH = C_ID_WIDTH_DEF
) (
    input  logic [C_REQ_NUM-1:0]  req,
    input  logic [C_ID_WIDTH-1:0] ptr,
    output logic                  any_req,
    output logic [C_ID_WIDTH-1:0] grant
);

    logic [C_ID_WIDTH-1:0] idx;

    // Scan from ptr; the first hit wins, later hits are ignored.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        idx     = '0;
        for (int i = 0; i < C_REQ_NUM; i++) begin
            idx = C_ID_WIDTH'((int'(ptr) + i) % C_REQ_NUM);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter in front of a single registered adder. One transaction
// is in flight at a time: accept, add, then hold the result until the owner
// takes it.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int C_REQ_NUM    = C_REQ_NUM_DEF,
    parameter int C_ID_WIDTH   = C_ID_WIDTH_DEF
) (
    input  logic                              I_sys_clk,
    input  logic                              I_rst,
    input  logic [C_REQ_NUM-1:0]              I_req_valid,
    output logic [C_REQ_NUM-1:0]              O_req_ready,
    input  logic [C_REQ_NUM*C_DATA_WIDTH-1:0] I_req_a,
    input  logic [C_REQ_NUM*C_DATA_WIDTH-1:0] I_req_b,
    output logic [C_REQ_NUM-1:0]              O_rsp_valid,
    input  logic [C_REQ_NUM-1:0]              I_rsp_ready,
    output logic [C_DATA_WIDTH:0]             O_rsp_sum,
    output logic [C_ID_WIDTH-1:0]             O_rsp_id,
    output logic                              O_busy
);

    localparam logic [C_ID_WIDTH-1:0] LAST_ID = C_ID_WIDTH'(C_REQ_NUM - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [C_ID_WIDTH-1:0]   rr_ptr_q;
    logic [C_DATA_WIDTH-1:0] a_q;
    logic [C_DATA_WIDTH-1:0] b_q;
    logic [C_ID_WIDTH-1:0]   id_q;
    logic [C_DATA_WIDTH:0]   sum_q;

    logic                    any_req;
    logic [C_ID_WIDTH-1:0]   grant_idx;
    logic [C_DATA_WIDTH-1:0] a_sel;
    logic [C_DATA_WIDTH-1:0] b_sel;
    logic [C_REQ_NUM-1:0]    grant_mask;
    logic [C_REQ_NUM-1:0]    owner_mask;
    logic                    rsp_ack;
    logic                    accept;
    logic                    rsp_done;

    rr_pick #(
        .C_REQ_NUM  (C_REQ_NUM),
        .C_ID_WIDTH (C_ID_WIDTH)
    ) u_rr_pick (
        .req     (I_req_valid),
        .ptr     (rr_ptr_q),
        .any_req (any_req),
        .grant   (grant_idx)
    );

    // Operand mux by constant lane offsets so unused lanes never leak X.
    always_comb begin
        a_sel      = '0;
        b_sel      = '0;
        grant_mask = '0;
        for (int k = 0; k < C_REQ_NUM; k++) begin
            if (grant_idx == C_ID_WIDTH'(k)) begin
                a_sel         = I_req_a[k*C_DATA_WIDTH +: C_DATA_WIDTH];
                b_sel         = I_req_b[k*C_DATA_WIDTH +: C_DATA_WIDTH];
                grant_mask[k] = 1'b1;
            end
        end
    end

    // One-hot of the current owner; only its ready bit can close a response.
    always_comb begin
        owner_mask = '0;
        for (int k = 0; k < C_REQ_NUM; k++) begin
            owner_mask[k] = (id_q == C_ID_WIDTH'(k));
        end
        rsp_ack = |(I_rsp_ready & owner_mask);
    end

    // Next-state and handshake outputs; ready is held off while reset is
    // asserted so no requester believes a dropped accept happened.
    always_comb begin
        state_d     = state_q;
        O_req_ready = '0;
        O_rsp_valid = '0;
        O_rsp_sum   = '0;
        O_rsp_id    = '0;
        accept      = 1'b0;
        rsp_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req && !I_rst) begin
                    accept      = 1'b1;
                    O_req_ready = grant_mask;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                O_rsp_valid = owner_mask;
                O_rsp_sum   = sum_q;
                O_rsp_id    = id_q;
                if (rsp_ack) begin
                    rsp_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign O_busy = (state_q != ST_IDLE);

    // State register and round-robin pointer; the pointer moves only when a
    // response completes, so a reset-dropped transaction does not advance it.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (rsp_done) begin
                rr_ptr_q <= (id_q == LAST_ID) ? '0 : id_q + C_ID_WIDTH'(1);
            end
        end
    end

    // Operand capture on accept and the shared registered adder.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= '0;
            sum_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= grant_idx;
            end
            if (state_q == ST_CALC) begin
                sum_q <= {1'b0, a_q} + {1'b0, b_q};
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios plus a randomized phase,
// with a transaction-level model checking every output on every cycle.
module tb_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           I_sys_clk = 1'b0;
    logic           I_rst;
    logic [N-1:0]   I_req_valid;
    logic [N-1:0]   O_req_ready;
    logic [N*W-1:0] I_req_a;
    logic [N*W-1:0] I_req_b;
    logic [N-1:0]   O_rsp_valid;
    logic [N-1:0]   I_rsp_ready;
    logic [W:0]     O_rsp_sum;
    logic [1:0]     O_rsp_id;
    logic           O_busy;

    int n_cmp = 0;
    int n_err = 0;

    adder_share_arbiter #(
        .C_DATA_WIDTH (W),
        .C_REQ_NUM    (N),
        .C_ID_WIDTH   (2)
    ) dut (
        .I_sys_clk   (I_sys_clk),
        .I_rst       (I_rst),
        .I_req_valid (I_req_valid),
        .O_req_ready (O_req_ready),
        .I_req_a     (I_req_a),
        .I_req_b     (I_req_b),
        .O_rsp_valid (O_rsp_valid),
        .I_rsp_ready (I_rsp_ready),
        .O_rsp_sum   (O_rsp_sum),
        .O_rsp_id    (O_rsp_id),
        .O_busy      (O_busy)
    );

    always #5 I_sys_clk = ~I_sys_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge I_sys_clk);
            #1;
        end
    endtask

    task automatic set_lane(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        I_req_a[k*W +: W] = a;
        I_req_b[k*W +: W] = b;
    endtask

    task automatic do_reset();
        I_rst       = 1'b1;
        I_req_valid = '0;
        I_rsp_ready = '0;
        wait_cyc(1);
        I_rst = 1'b0;
    endtask

    // Transaction model: one outstanding request, result visible from the
    // second cycle after accept, pointer moves past the owner on completion.
    bit         mon_en  = 1'b0;
    bit         m_pend  = 1'b0;
    int         m_ptr   = 0;
    int         m_owner = 0;
    int         m_age   = 0;
    logic [W:0] m_sum   = '0;

    always @(negedge I_sys_clk) begin
        logic [N-1:0] e_rr;
        logic [N-1:0] e_rv;
        logic [W:0]   e_sum;
        int           e_id;
        int           g;
        if (mon_en) begin
            g     = pick(I_req_valid, m_ptr);
            e_rr  = '0;
            e_rv  = '0;
            e_sum = '0;
            e_id  = 0;
            if (!m_pend && !I_rst && g >= 0) e_rr[g] = 1'b1;
            if (m_pend && m_age >= 2) begin
                e_rv[m_owner] = 1'b1;
                e_sum         = m_sum;
                e_id          = m_owner;
            end
            check_val("mon_req_ready", 32'(O_req_ready), 32'(e_rr));
            check_val("mon_rsp_valid", 32'(O_rsp_valid), 32'(e_rv));
            check_val("mon_rsp_sum",   32'(O_rsp_sum),   32'(e_sum));
            check_val("mon_rsp_id",    32'(O_rsp_id),    32'(e_id));
            check_val("mon_busy",      32'(O_busy),      32'(m_pend));
            if (I_rst) begin
                m_pend = 1'b0;
                m_ptr  = 0;
            end else if (m_pend) begin
                if (m_age >= 2 && I_rsp_ready[m_owner]) begin
                    m_pend = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end else begin
                    m_age++;
                end
            end else if (g >= 0) begin
                m_pend  = 1'b1;
                m_owner = g;
                m_age   = 1;
                m_sum   = {1'b0, I_req_a[g*W +: W]} + {1'b0, I_req_b[g*W +: W]};
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         gidx[5];
        int         gcyc[5];
        logic [W:0] sums[4];
        int         exp_g[5];
        int         n_g;
        int         n_s;
        logic [N-1:0] rr;

        exp_g = '{0, 1, 2, 3, 0};
        I_rst       = 1'b1;
        I_req_valid = '0;
        I_rsp_ready = '0;
        I_req_a     = '0;
        I_req_b     = '0;
        @(posedge I_sys_clk);
        #1;
        mon_en = 1'b1;
        #2;
        check_val("reset_busy",      32'(O_busy),      32'd0);
        check_val("reset_rsp_valid", 32'(O_rsp_valid), 32'd0);
        check_val("reset_req_ready", 32'(O_req_ready), 32'd0);
        wait_cyc(1);
        I_rst = 1'b0;

        // single request after reset
        I_req_valid = 4'b0001;
        set_lane(0, 4'h9, 4'h8);
        #2;
        check_val("t1_req_ready", 32'(O_req_ready), 32'h1);
        wait_cyc(1);
        I_req_valid = '0;
        wait_cyc(1);
        #2;
        check_val("t1_rsp_valid", 32'(O_rsp_valid), 32'h1);
        check_val("t1_rsp_sum",   32'(O_rsp_sum),   32'h11);
        check_val("t1_rsp_id",    32'(O_rsp_id),    32'h0);
        I_rsp_ready = 4'b0001;
        wait_cyc(1);
        I_rsp_ready = '0;
        #2;
        check_val("t1_busy_after", 32'(O_busy), 32'h0);

        // all four continuously valid from pointer 0
        do_reset();
        for (int k = 0; k < N; k++) set_lane(k, W'(k), 4'hF);
        I_req_valid = 4'b1111;
        n_g = 0;
        n_s = 0;
        for (int c = 0; c < 40 && n_g < 5; c++) begin
            #2;
            I_rsp_ready = O_rsp_valid;
            if (O_rsp_valid != '0 && n_s < 4) begin
                sums[n_s] = O_rsp_sum;
                n_s++;
            end
            if (O_req_ready != '0) begin
                gidx[n_g] = onehot_idx(O_req_ready);
                gcyc[n_g] = c;
                n_g++;
            end
            wait_cyc(1);
        end
        I_req_valid = '0;
        I_rsp_ready = '0;
        check_val("t2_grant_count", 32'(n_g), 32'd5);
        check_val("t2_sum_count",   32'(n_s), 32'd4);
        for (int i = 0; i < n_g; i++) begin
            check_val("t2_grant_order", 32'(gidx[i]), 32'(exp_g[i]));
            if (i > 0) check_val("t2_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        for (int i = 0; i < n_s; i++) check_val("t2_sum", 32'(sums[i]), 32'(i + 15));
        wait_cyc(1);
        #2;
        I_rsp_ready = 4'b1111;
        wait_cyc(1);
        I_rsp_ready = '0;

        // backpressure on requester 2
        do_reset();
        set_lane(2, 4'h1, 4'h2);
        set_lane(1, 4'h3, 4'h4);
        I_req_valid = 4'b0100;
        #2;
        check_val("t3_req_ready", 32'(O_req_ready), 32'h4);
        wait_cyc(1);
        I_req_valid = 4'b0010;
        wait_cyc(1);
        for (int c = 0; c < 5; c++) begin
            I_rsp_ready = (c % 2 == 0) ? 4'b0001 : 4'b1011;
            #2;
            check_val("t3_hold_valid", 32'(O_rsp_valid), 32'h4);
            check_val("t3_hold_sum",   32'(O_rsp_sum),   32'h03);
            check_val("t3_no_ready",   32'(O_req_ready), 32'h0);
            wait_cyc(1);
        end
        I_rsp_ready = 4'b0100;
        #2;
        check_val("t3_still_valid", 32'(O_rsp_valid), 32'h4);
        wait_cyc(1);
        I_rsp_ready = '0;
        #2;
        check_val("t3_next_grant", 32'(O_req_ready), 32'h2);
        wait_cyc(1);
        I_req_valid = '0;
        wait_cyc(1);
        I_rsp_ready = 4'b0010;
        wait_cyc(1);
        I_rsp_ready = '0;

        // pointer wrap after requester 3
        do_reset();
        set_lane(3, 4'hF, 4'hF);
        set_lane(0, 4'h5, 4'h6);
        I_req_valid = 4'b1000;
        #2;
        check_val("t4_req_ready3", 32'(O_req_ready), 32'h8);
        wait_cyc(1);
        I_req_valid = 4'b1001;
        wait_cyc(1);
        #2;
        check_val("t4_sum", 32'(O_rsp_sum), 32'h1E);
        check_val("t4_id",  32'(O_rsp_id),  32'h3);
        I_rsp_ready = 4'b1000;
        wait_cyc(1);
        I_rsp_ready = '0;
        #2;
        check_val("t4_wrap_grant", 32'(O_req_ready), 32'h1);
        wait_cyc(1);
        I_req_valid = 4'b1000;
        wait_cyc(1);
        I_rsp_ready = 4'b0001;
        wait_cyc(1);
        I_rsp_ready = '0;
        #2;
        check_val("t4_grant3_again", 32'(O_req_ready), 32'h8);
        wait_cyc(1);
        I_req_valid = '0;
        wait_cyc(1);
        I_rsp_ready = 4'b1000;
        wait_cyc(1);
        I_rsp_ready = '0;

        // reset while calculating
        set_lane(2, 4'h7, 4'h7);
        I_req_valid = 4'b0100;
        #2;
        check_val("t5_req_ready", 32'(O_req_ready), 32'h4);
        wait_cyc(1);
        I_req_valid = '0;
        I_rst = 1'b1;
        #2;
        check_val("t5_busy_calc", 32'(O_busy), 32'h1);
        wait_cyc(1);
        I_rst = 1'b0;
        #2;
        check_val("t5_busy",      32'(O_busy),      32'h0);
        check_val("t5_rsp_valid", 32'(O_rsp_valid), 32'h0);
        check_val("t5_rsp_sum",   32'(O_rsp_sum),   32'h0);
        check_val("t5_rsp_id",    32'(O_rsp_id),    32'h0);
        for (int c = 0; c < 4; c++) begin
            wait_cyc(1);
            #2;
            check_val("t5_no_rsp", 32'(O_rsp_valid), 32'h0);
        end
        set_lane(3, 4'h1, 4'h1);
        I_req_valid = 4'b1100;
        #2;
        check_val("t5_lowest_grant", 32'(O_req_ready), 32'h4);
        wait_cyc(1);
        I_req_valid = '0;
        wait_cyc(1);
        #2;
        check_val("t5_sum_after", 32'(O_rsp_sum), 32'h0E);
        I_rsp_ready = 4'b0100;
        wait_cyc(1);
        I_rsp_ready = '0;

        // idle
        for (int c = 0; c < 10; c++) begin
            #2;
            check_val("t6_req_ready", 32'(O_req_ready), 32'h0);
            check_val("t6_rsp_valid", 32'(O_rsp_valid), 32'h0);
            check_val("t6_busy",      32'(O_busy),      32'h0);
            wait_cyc(1);
        end

        // randomized traffic, requesters honour hold-until-ready
        for (int c = 0; c < 2000; c++) begin
            @(negedge I_sys_clk);
            rr = O_req_ready;
            @(posedge I_sys_clk);
            #1;
            I_rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                if (I_req_valid[k] && rr[k]) begin
                    I_req_valid[k] = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin
                        I_req_valid[k] = 1'b1;
                        set_lane(k, W'($urandom), W'($urandom));
                    end
                end else if (!I_req_valid[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        I_req_valid[k] = 1'b1;
                        set_lane(k, W'($urandom), W'($urandom));
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    I_req_valid[k] = 1'b0;
                end
            end
            I_rsp_ready = N'($urandom);
        end
        I_rst       = 1'b0;
        I_req_valid = '0;
        I_rsp_ready = '0;
        wait_cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
